// File: rtl/wb_pkg.sv
// Shared types and defaults for the writeback producer and its load buffer.
package wb_pkg;

    localparam int DATA_W_DEF     = 16;
    localparam int ADR_W_DEF      = 3;
    localparam int FIFO_DEPTH_DEF = 2;
    localparam int NUM_REGS       = 8;

    // One register-file write command.
    typedef struct packed {
        logic                  ena;
        logic [ADR_W_DEF-1:0]  adr;
        logic [DATA_W_DEF-1:0] data;
    } wr_reg_t;

    // Flag-register write commands: compare flags and address-equality flag.
    typedef struct packed {
        logic ena;
        logic ravno;
        logic bolshe;
        logic menshe;
        logic ena_ra;
        logic rav_adr;
    } flag_wr_t;

    // Buffered load result; live drops when a younger ALU write hits the same register.
    typedef struct packed {
        logic                  live;
        logic [ADR_W_DEF-1:0]  adr;
        logic [DATA_W_DEF-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small circular buffer of load results with per-entry kill by destination address
// and a mask of registers that still have a live buffered write.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                       clk_i,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  wb_entry_t                  push_entry_i,
    input  logic                       pop_i,
    input  logic                       kill_ena_i,
    input  logic [ADR_W_DEF-1:0]       kill_adr_i,
    output wb_entry_t                  head_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic [NUM_REGS-1:0]        live_mask_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    wb_entry_t        entries [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    // Storage and pointers; popped slots lose their live bit so the mask only sees occupied entries.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (kill_ena_i && entries[i].adr == kill_adr_i) begin
                    entries[i].live <= 1'b0;
                end
            end
            if (pop_i) begin
                entries[rd_ptr].live <= 1'b0;
                rd_ptr               <= rd_ptr + PTR_W'(1);
            end
            if (push_i) begin
                entries[wr_ptr] <= push_entry_i;
                wr_ptr          <= wr_ptr + PTR_W'(1);
            end
            case ({push_i, pop_i})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Decode which registers still have a live buffered load.
    always_comb begin
        live_mask_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entries[i].live) begin
                live_mask_o[entries[i].adr] = 1'b1;
            end
        end
    end

    assign head_o  = entries[rd_ptr];
    assign count_o = count;

endmodule

// File: rtl/wb_writer.sv
// Writeback producer: arbitrates ALU and load results onto the register write port,
// buffers loads that lose arbitration, and produces compare flag writes.
module wb_writer
    import wb_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int ADR_W      = ADR_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                clk_i,
    input  logic                rst_n,
    input  logic                alu_valid_i,
    input  logic [ADR_W-1:0]    alu_adr_i,
    input  logic [DATA_W-1:0]   alu_data_i,
    input  logic                mem_valid_i,
    output logic                mem_ready_o,
    input  logic [ADR_W-1:0]    mem_adr_i,
    input  logic [DATA_W-1:0]   mem_data_i,
    input  logic                cmp_valid_i,
    input  logic [DATA_W-1:0]   cmp_a_i,
    input  logic [DATA_W-1:0]   cmp_b_i,
    input  logic                cmpa_valid_i,
    input  logic [DATA_W-1:0]   cmpa_adr_i,
    input  logic [DATA_W-1:0]   cmpa_ref_i,
    output logic                wr_ena_o,
    output logic [ADR_W-1:0]    wr_adr_o,
    output logic [DATA_W-1:0]   wr_data_o,
    output logic                flag_ena_o,
    output logic                flag_ravno_o,
    output logic                flag_bolshe_o,
    output logic                flag_menshe_o,
    output logic                flag_ena_ra_o,
    output logic                flag_rav_adr_o,
    output logic [NUM_REGS-1:0] pending_o
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    wb_entry_t          fifo_head;
    wb_entry_t          push_entry;
    logic [CNT_W-1:0]   fifo_count;
    logic [NUM_REGS-1:0] fifo_mask;
    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_empty;
    logic               load_accept;
    logic               load_bypass;
    logic               run_q;
    wr_reg_t            wr_q;
    wr_reg_t            wr_d;
    flag_wr_t           flag_q;
    flag_wr_t           flag_d;

    wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i        (clk_i),
        .rst_n        (rst_n),
        .push_i       (fifo_push),
        .push_entry_i (push_entry),
        .pop_i        (fifo_pop),
        .kill_ena_i   (alu_valid_i),
        .kill_adr_i   (alu_adr_i),
        .head_o       (fifo_head),
        .count_o      (fifo_count),
        .live_mask_o  (fifo_mask)
    );

    // Ready is held low during reset and for the first edge after, then follows FIFO space.
    assign mem_ready_o = run_q && (fifo_count < CNT_W'(FIFO_DEPTH));
    assign load_accept = mem_valid_i && mem_ready_o;
    assign fifo_empty  = (fifo_count == '0);

    // A load that collides with an ALU write to the same register is older, so it enters already dead.
    assign push_entry = '{live: !(alu_valid_i && alu_adr_i == mem_adr_i),
                          adr:  mem_adr_i,
                          data: mem_data_i};
    assign fifo_push  = load_accept && !load_bypass;

    // Write-port arbitration: ALU first, then buffered loads, then a direct load bypass.
    always_comb begin
        wr_d        = '{ena: 1'b0, adr: wr_q.adr, data: wr_q.data};
        fifo_pop    = 1'b0;
        load_bypass = 1'b0;
        if (alu_valid_i) begin
            wr_d = '{ena: 1'b1, adr: alu_adr_i, data: alu_data_i};
        end else if (!fifo_empty) begin
            fifo_pop = 1'b1;
            wr_d     = '{ena: fifo_head.live, adr: fifo_head.adr, data: fifo_head.data};
        end else if (load_accept) begin
            load_bypass = 1'b1;
            wr_d        = '{ena: 1'b1, adr: mem_adr_i, data: mem_data_i};
        end
    end

    // Flag results; values hold between requests, only the enables drop.
    always_comb begin
        flag_d        = flag_q;
        flag_d.ena    = 1'b0;
        flag_d.ena_ra = 1'b0;
        if (cmp_valid_i) begin
            flag_d.ena    = 1'b1;
            flag_d.ravno  = (cmp_a_i == cmp_b_i);
            flag_d.bolshe = (cmp_a_i > cmp_b_i);
            flag_d.menshe = (cmp_a_i < cmp_b_i);
        end
        if (cmpa_valid_i) begin
            flag_d.ena_ra  = 1'b1;
            flag_d.rav_adr = (cmpa_adr_i == cmpa_ref_i);
        end
    end

    // Output registers and the post-reset run flag.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            run_q  <= 1'b0;
            wr_q   <= '0;
            flag_q <= '0;
        end else begin
            run_q  <= 1'b1;
            wr_q   <= wr_d;
            flag_q <= flag_d;
        end
    end

    assign wr_ena_o       = wr_q.ena;
    assign wr_adr_o       = wr_q.adr;
    assign wr_data_o      = wr_q.data;
    assign flag_ena_o     = flag_q.ena;
    assign flag_ravno_o   = flag_q.ravno;
    assign flag_bolshe_o  = flag_q.bolshe;
    assign flag_menshe_o  = flag_q.menshe;
    assign flag_ena_ra_o  = flag_q.ena_ra;
    assign flag_rav_adr_o = flag_q.rav_adr;
    assign pending_o      = fifo_mask;

endmodule

// File: tb/tb_wb_writer.sv
// Scoreboard bench for wb_writer: stimulus steps a queue-based reference model and
// pushes expected responses; a negedge monitor pops and compares them.
module tb_wb_writer;

    localparam int DEPTH = 2;

    logic        clk_i;
    logic        rst_n;
    logic        alu_valid_i;
    logic [2:0]  alu_adr_i;
    logic [15:0] alu_data_i;
    logic        mem_valid_i;
    logic        mem_ready_o;
    logic [2:0]  mem_adr_i;
    logic [15:0] mem_data_i;
    logic        cmp_valid_i;
    logic [15:0] cmp_a_i;
    logic [15:0] cmp_b_i;
    logic        cmpa_valid_i;
    logic [15:0] cmpa_adr_i;
    logic [15:0] cmpa_ref_i;
    logic        wr_ena_o;
    logic [2:0]  wr_adr_o;
    logic [15:0] wr_data_o;
    logic        flag_ena_o;
    logic        flag_ravno_o;
    logic        flag_bolshe_o;
    logic        flag_menshe_o;
    logic        flag_ena_ra_o;
    logic        flag_rav_adr_o;
    logic [7:0]  pending_o;

    wb_writer dut (
        .clk_i          (clk_i),
        .rst_n          (rst_n),
        .alu_valid_i    (alu_valid_i),
        .alu_adr_i      (alu_adr_i),
        .alu_data_i     (alu_data_i),
        .mem_valid_i    (mem_valid_i),
        .mem_ready_o    (mem_ready_o),
        .mem_adr_i      (mem_adr_i),
        .mem_data_i     (mem_data_i),
        .cmp_valid_i    (cmp_valid_i),
        .cmp_a_i        (cmp_a_i),
        .cmp_b_i        (cmp_b_i),
        .cmpa_valid_i   (cmpa_valid_i),
        .cmpa_adr_i     (cmpa_adr_i),
        .cmpa_ref_i     (cmpa_ref_i),
        .wr_ena_o       (wr_ena_o),
        .wr_adr_o       (wr_adr_o),
        .wr_data_o      (wr_data_o),
        .flag_ena_o     (flag_ena_o),
        .flag_ravno_o   (flag_ravno_o),
        .flag_bolshe_o  (flag_bolshe_o),
        .flag_menshe_o  (flag_menshe_o),
        .flag_ena_ra_o  (flag_ena_ra_o),
        .flag_rav_adr_o (flag_rav_adr_o),
        .pending_o      (pending_o)
    );

    typedef struct { int cyc; logic [2:0] adr; logic [15:0] data; } exp_wr_t;
    typedef struct { int cyc; logic [2:0] flags; } exp_flag_t;
    typedef struct { int cyc; logic eq; } exp_ra_t;
    typedef struct { int cyc; logic [7:0] pend; logic rdy; } exp_st_t;
    typedef struct { logic live; logic [2:0] adr; logic [15:0] data; } mdl_ent_t;

    exp_wr_t   exp_wr[$];
    exp_flag_t exp_flag[$];
    exp_ra_t   exp_ra[$];
    exp_st_t   exp_st[$];
    mdl_ent_t  mdl_q[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit checking = 0;

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Cycle stamp used to line up expectations with DUT outputs.
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Drive one cycle of inputs, step the reference model, and record the expected response.
    task automatic apply_stimulus(input bit av, input logic [2:0] aa, input logic [15:0] ad,
                                  input bit mv, input logic [2:0] ma, input logic [15:0] md,
                                  input bit cv, input logic [15:0] ca, input logic [15:0] cb,
                                  input bit rv, input logic [15:0] ra, input logic [15:0] rr);
        bit       rdy;
        bit       acc;
        bit       byp;
        mdl_ent_t h;
        logic [7:0] pend;
        alu_valid_i  = av;  alu_adr_i  = aa; alu_data_i = ad;
        mem_valid_i  = mv;  mem_adr_i  = ma; mem_data_i = md;
        cmp_valid_i  = cv;  cmp_a_i    = ca; cmp_b_i    = cb;
        cmpa_valid_i = rv;  cmpa_adr_i = ra; cmpa_ref_i = rr;
        rdy = (mdl_q.size() < DEPTH);
        acc = mv && rdy;
        byp = 0;
        if (av) begin
            exp_wr.push_back('{cyc + 1, aa, ad});
            foreach (mdl_q[i]) if (mdl_q[i].adr == aa) mdl_q[i].live = 1'b0;
        end else if (mdl_q.size() > 0) begin
            h = mdl_q.pop_front();
            if (h.live) exp_wr.push_back('{cyc + 1, h.adr, h.data});
        end else if (acc) begin
            exp_wr.push_back('{cyc + 1, ma, md});
            byp = 1;
        end
        if (acc && !byp) mdl_q.push_back('{!(av && aa == ma), ma, md});
        pend = '0;
        foreach (mdl_q[i]) if (mdl_q[i].live) pend[mdl_q[i].adr] = 1'b1;
        exp_st.push_back('{cyc + 1, pend, mdl_q.size() < DEPTH});
        if (cv) exp_flag.push_back('{cyc + 1, {ca == cb, ca > cb, ca < cb}});
        if (rv) exp_ra.push_back('{cyc + 1, ra == rr});
        @(negedge clk_i);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_wr_ena"},   wr_ena_o, 0);
        check_output({tag, "_wr_adr"},   wr_adr_o, 0);
        check_output({tag, "_wr_data"},  wr_data_o, 0);
        check_output({tag, "_flags"},    {flag_ena_o, flag_ravno_o, flag_bolshe_o, flag_menshe_o,
                                          flag_ena_ra_o, flag_rav_adr_o}, 0);
        check_output({tag, "_ready"},    mem_ready_o, 0);
        check_output({tag, "_pending"},  pending_o, 0);
    endtask

    // Enter reset (optionally checking the asynchronous clear), hold it, then release.
    task automatic do_reset(input bit mid, input int hold);
        checking = 0;
        exp_wr.delete(); exp_flag.delete(); exp_ra.delete(); exp_st.delete(); mdl_q.delete();
        rst_n = 1'b0;
        alu_valid_i = 0; mem_valid_i = 0; cmp_valid_i = 0; cmpa_valid_i = 0;
        if (mid) begin
            #1;
            check_reset_outputs("rst_async");
        end
        repeat (hold) @(negedge clk_i);
        check_reset_outputs("rst_hold");
        rst_n = 1'b1;
        @(negedge clk_i);
        check_output("rst_release_ready", mem_ready_o, 1);
        check_output("rst_release_pending", pending_o, 0);
        checking = 1;
    endtask

    // Monitor: compare DUT outputs with whatever the model expected for this cycle.
    always @(negedge clk_i) begin
        if (checking) begin
            if (exp_wr.size() > 0 && exp_wr[0].cyc == cyc) begin
                exp_wr_t e;
                e = exp_wr.pop_front();
                check_output("wr_ena", wr_ena_o, 1);
                check_output("wr_adr", wr_adr_o, e.adr);
                check_output("wr_data", wr_data_o, e.data);
            end else begin
                check_output("wr_ena_idle", wr_ena_o, 0);
            end
            if (exp_flag.size() > 0 && exp_flag[0].cyc == cyc) begin
                exp_flag_t f;
                f = exp_flag.pop_front();
                check_output("flag_ena", flag_ena_o, 1);
                check_output("flag_vals", {flag_ravno_o, flag_bolshe_o, flag_menshe_o}, f.flags);
            end else begin
                check_output("flag_ena_idle", flag_ena_o, 0);
            end
            if (exp_ra.size() > 0 && exp_ra[0].cyc == cyc) begin
                exp_ra_t r;
                r = exp_ra.pop_front();
                check_output("flag_ena_ra", flag_ena_ra_o, 1);
                check_output("flag_rav_adr", flag_rav_adr_o, r.eq);
            end else begin
                check_output("flag_ena_ra_idle", flag_ena_ra_o, 0);
            end
            if (exp_st.size() > 0 && exp_st[0].cyc == cyc) begin
                exp_st_t s;
                s = exp_st.pop_front();
                check_output("pending", pending_o, s.pend);
                check_output("mem_ready", mem_ready_o, s.rdy);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        alu_valid_i = 0; alu_adr_i = 0; alu_data_i = 0;
        mem_valid_i = 0; mem_adr_i = 0; mem_data_i = 0;
        cmp_valid_i = 0; cmp_a_i = 0; cmp_b_i = 0;
        cmpa_valid_i = 0; cmpa_adr_i = 0; cmpa_ref_i = 0;
        @(negedge clk_i);
        do_reset(0, 3);

        // Bypass of a load with an empty buffer and no ALU traffic.
        apply_stimulus(0, 0, 0, 1, 3, 16'h1234, 0, 0, 0, 0, 0, 0);
        idle_cycles(2);

        // ALU and load in the same cycle: ALU first, load buffered then written.
        apply_stimulus(1, 1, 16'hAAAA, 1, 2, 16'h5555, 0, 0, 0, 0, 0, 0);
        idle_cycles(3);

        // Buffered load to r5 killed by a later ALU write to r5.
        apply_stimulus(1, 0, 16'h1111, 1, 5, 16'hBEEF, 0, 0, 0, 0, 0, 0);
        apply_stimulus(1, 5, 16'h0F0F, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle_cycles(3);

        // Same-cycle collision on one register: the load enters already dead.
        apply_stimulus(1, 6, 16'h6666, 1, 6, 16'h7777, 0, 0, 0, 0, 0, 0);
        idle_cycles(3);

        // Backpressure: ALU held while loads are offered every cycle.
        for (int i = 0; i < 6; i++)
            apply_stimulus(1, 3'(i), 16'(16'h0100 + i), 1, 3'(i + 4), 16'(16'hC000 + i), 0, 0, 0, 0, 0, 0);
        idle_cycles(4);

        // Flag writes: greater-than plus equal address, then equal, then less, then address miss.
        apply_stimulus(0, 0, 0, 0, 0, 0, 1, 16'h8000, 16'h7FFF, 1, 16'h0010, 16'h0010);
        apply_stimulus(0, 0, 0, 0, 0, 0, 1, 16'h4242, 16'h4242, 0, 0, 0);
        apply_stimulus(0, 0, 0, 0, 0, 0, 1, 16'h0000, 16'hFFFF, 1, 16'h0010, 16'h0011);
        idle_cycles(2);

        // Reset while the buffer holds loads.
        apply_stimulus(1, 0, 16'h0001, 1, 1, 16'h0002, 0, 0, 0, 0, 0, 0);
        apply_stimulus(1, 2, 16'h0003, 1, 4, 16'h0004, 0, 0, 0, 0, 0, 0);
        do_reset(1, 2);
        idle_cycles(2);

        // Randomized traffic with a narrow address range to provoke kills and hazards.
        for (int i = 0; i < 600; i++) begin
            bit          av, mv, cv, rv;
            logic [2:0]  aa, ma;
            logic [15:0] ca, cb, ra, rr;
            av = ($urandom_range(0, 9) < 4);
            mv = ($urandom_range(0, 9) < 6);
            aa = ($urandom_range(0, 1) == 1) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
            ma = ($urandom_range(0, 1) == 1) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
            cv = ($urandom_range(0, 2) == 0);
            rv = ($urandom_range(0, 2) == 0);
            ca = 16'($urandom);
            cb = ($urandom_range(0, 3) == 0) ? ca : 16'($urandom);
            ra = 16'($urandom_range(0, 7));
            rr = 16'($urandom_range(0, 7));
            apply_stimulus(av, aa, 16'($urandom), mv, ma, 16'($urandom), cv, ca, cb, rv, ra, rr);
        end
        idle_cycles(5);

        check_output("drain_wr_queue", exp_wr.size(), 0);
        check_output("drain_flag_queue", exp_flag.size() + exp_ra.size(), 0);
        check_output("drain_model", mdl_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
